// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite response codes and FSM state encodings for the register-file slave.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    W_ACCEPT = 1'b0,
    W_RESP   = 1'b1
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } r_state_t;

endpackage

// File: rtl/axi4_lite_regfile_core.sv
// NUM_REGS x 32-bit register storage with a byte-strobed write port,
// flat register export and a one-cycle per-register write strobe.
module axi4_lite_regfile_core #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_idx,
  input  logic [31:0]              wr_data,
  input  logic [3:0]               wr_strb,
  output logic [32*NUM_REGS-1:0]   reg_q,
  output logic [NUM_REGS-1:0]      reg_wstb
);

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [31:0] q_reg;
    logic        wstb_reg;
    logic        hit;

    assign hit = wr_en && (wr_idx == IDX_W'(gi));

    // The strobe fires on any addressed commit, even when no byte lane is enabled.
    always_ff @(posedge clk) begin
      if (srst) begin
        q_reg    <= '0;
        wstb_reg <= 1'b0;
      end else begin
        wstb_reg <= hit;
        for (int b = 0; b < 4; b++) begin
          if (hit && wr_strb[b]) begin
            q_reg[8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
    end

    assign reg_q[32*gi +: 32] = q_reg;
    assign reg_wstb[gi]       = wstb_reg;
  end

endmodule

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave register file with independent write/read FSMs.
// Define AXIL_SLAVE_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axi4_lite_slave_regfile
  import axi4_lite_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int NUM_REGS       = 16
) (
  input  logic                        S_AXI_ACLK,
  input  logic                        S_AXI_ARESET,
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                        S_AXI_AWVALID,
  output logic                        S_AXI_AWREADY,
  input  logic [2:0]                  S_AXI_AWPROT,
  input  logic [AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [3:0]                  S_AXI_WSTRB,
  input  logic                        S_AXI_WVALID,
  output logic                        S_AXI_WREADY,
  output logic [1:0]                  S_AXI_BRESP,
  output logic                        S_AXI_BVALID,
  input  logic                        S_AXI_BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                        S_AXI_ARVALID,
  output logic                        S_AXI_ARREADY,
  input  logic [2:0]                  S_AXI_ARPROT,
  output logic [AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                  S_AXI_RRESP,
  output logic                        S_AXI_RVALID,
  input  logic                        S_AXI_RREADY,
  output logic [32*NUM_REGS-1:0]      REG_Q,
  output logic [NUM_REGS-1:0]         REG_WSTB
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

`ifdef AXIL_SLAVE_SLVERR_EN
  localparam logic [1:0] ERR_RESP = RESP_SLVERR;
`else
  localparam logic [1:0] ERR_RESP = RESP_OKAY;
`endif

  // Full-width compare so that any set upper address bit lands out of range.
  function automatic logic in_range(input logic [AXI_ADDR_WIDTH-1:0] a);
    return (a >> 2) < AXI_ADDR_WIDTH'(NUM_REGS);
  endfunction

  w_state_t                    w_state_reg, w_state_next;
  logic                        aw_held_reg, aw_held_next;
  logic                        w_held_reg, w_held_next;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr_reg, aw_addr_next;
  logic [31:0]                 w_data_reg, w_data_next;
  logic [3:0]                  w_strb_reg, w_strb_next;
  logic                        aw_ready_reg, aw_ready_next;
  logic                        w_ready_reg, w_ready_next;
  logic                        b_valid_reg, b_valid_next;
  logic [1:0]                  b_resp_reg, b_resp_next;
  logic                        commit, cm_in_range;

  r_state_t                    r_state_reg, r_state_next;
  logic                        ar_ready_reg, ar_ready_next;
  logic                        r_valid_reg, r_valid_next;
  logic [31:0]                 r_data_reg, r_data_next;
  logic [1:0]                  r_resp_reg, r_resp_next;
  logic                        ar_in_range;
  logic [IDX_W-1:0]            ar_idx;

  logic [31:0]                 reg_arr [NUM_REGS];
  logic                        unused_prot;

  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_view
    assign reg_arr[gi] = REG_Q[32*gi +: 32];
  end

  assign cm_in_range = in_range(aw_addr_next);
  assign ar_in_range = in_range(S_AXI_ARADDR);
  assign ar_idx      = S_AXI_ARADDR[2 +: IDX_W];

  always_comb begin
    w_state_next  = w_state_reg;
    aw_held_next  = aw_held_reg;
    w_held_next   = w_held_reg;
    aw_addr_next  = aw_addr_reg;
    w_data_next   = w_data_reg;
    w_strb_next   = w_strb_reg;
    aw_ready_next = aw_ready_reg;
    w_ready_next  = w_ready_reg;
    b_valid_next  = b_valid_reg;
    b_resp_next   = b_resp_reg;
    commit        = 1'b0;
    case (w_state_reg)
      W_ACCEPT: begin
        if (S_AXI_AWVALID && aw_ready_reg) begin
          aw_addr_next = S_AXI_AWADDR;
          aw_held_next = 1'b1;
        end
        if (S_AXI_WVALID && w_ready_reg) begin
          w_data_next = S_AXI_WDATA[31:0];
          w_strb_next = S_AXI_WSTRB;
          w_held_next = 1'b1;
        end
        if (aw_held_next && w_held_next) begin
          commit        = 1'b1;
          aw_held_next  = 1'b0;
          w_held_next   = 1'b0;
          b_valid_next  = 1'b1;
          b_resp_next   = cm_in_range ? RESP_OKAY : ERR_RESP;
          aw_ready_next = 1'b0;
          w_ready_next  = 1'b0;
          w_state_next  = W_RESP;
        end else begin
          aw_ready_next = ~aw_held_next;
          w_ready_next  = ~w_held_next;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          b_valid_next  = 1'b0;
          aw_ready_next = 1'b1;
          w_ready_next  = 1'b1;
          w_state_next  = W_ACCEPT;
        end
      end
    endcase
  end

  // Storage updates on the same edge as the AR capture, so a colliding read sees the old value.
  always_comb begin
    r_state_next  = r_state_reg;
    ar_ready_next = ar_ready_reg;
    r_valid_next  = r_valid_reg;
    r_data_next   = r_data_reg;
    r_resp_next   = r_resp_reg;
    case (r_state_reg)
      R_IDLE: begin
        ar_ready_next = 1'b1;
        if (S_AXI_ARVALID && ar_ready_reg) begin
          r_data_next   = ar_in_range ? reg_arr[ar_idx] : 32'd0;
          r_resp_next   = ar_in_range ? RESP_OKAY : ERR_RESP;
          r_valid_next  = 1'b1;
          ar_ready_next = 1'b0;
          r_state_next  = R_RESP;
        end
      end
      R_RESP: begin
        if (S_AXI_RREADY) begin
          r_valid_next  = 1'b0;
          ar_ready_next = 1'b1;
          r_state_next  = R_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      w_state_reg  <= W_ACCEPT;
      aw_held_reg  <= 1'b0;
      w_held_reg   <= 1'b0;
      aw_addr_reg  <= '0;
      w_data_reg   <= '0;
      w_strb_reg   <= '0;
      aw_ready_reg <= 1'b0;
      w_ready_reg  <= 1'b0;
      b_valid_reg  <= 1'b0;
      b_resp_reg   <= RESP_OKAY;
      r_state_reg  <= R_IDLE;
      ar_ready_reg <= 1'b0;
      r_valid_reg  <= 1'b0;
      r_data_reg   <= '0;
      r_resp_reg   <= RESP_OKAY;
    end else begin
      w_state_reg  <= w_state_next;
      aw_held_reg  <= aw_held_next;
      w_held_reg   <= w_held_next;
      aw_addr_reg  <= aw_addr_next;
      w_data_reg   <= w_data_next;
      w_strb_reg   <= w_strb_next;
      aw_ready_reg <= aw_ready_next;
      w_ready_reg  <= w_ready_next;
      b_valid_reg  <= b_valid_next;
      b_resp_reg   <= b_resp_next;
      r_state_reg  <= r_state_next;
      ar_ready_reg <= ar_ready_next;
      r_valid_reg  <= r_valid_next;
      r_data_reg   <= r_data_next;
      r_resp_reg   <= r_resp_next;
    end
  end

  axi4_lite_regfile_core #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_core (
    .clk      (S_AXI_ACLK),
    .srst     (S_AXI_ARESET),
    .wr_en    (commit && cm_in_range),
    .wr_idx   (aw_addr_next[2 +: IDX_W]),
    .wr_data  (w_data_next),
    .wr_strb  (w_strb_next),
    .reg_q    (REG_Q),
    .reg_wstb (REG_WSTB)
  );

  assign S_AXI_AWREADY = aw_ready_reg;
  assign S_AXI_WREADY  = w_ready_reg;
  assign S_AXI_BVALID  = b_valid_reg;
  assign S_AXI_BRESP   = b_resp_reg;
  assign S_AXI_ARREADY = ar_ready_reg;
  assign S_AXI_RVALID  = r_valid_reg;
  assign S_AXI_RDATA   = AXI_DATA_WIDTH'(r_data_reg);
  assign S_AXI_RRESP   = r_resp_reg;

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Scoreboard bench for axi4_lite_slave_regfile: directed writes/reads, backpressure, collision, range and reset cases.
module tb_axi4_lite_slave_regfile;
  import axi4_lite_pkg::*;

  localparam int NREG = 16;

`ifdef AXIL_SLAVE_SLVERR_EN
  localparam logic [1:0] ERR = RESP_SLVERR;
`else
  localparam logic [1:0] ERR = RESP_OKAY;
`endif

  logic              clk = 1'b0;
  logic              areset;
  logic [31:0]       awaddr, wdata, araddr, rdata;
  logic [3:0]        wstrb;
  logic [2:0]        awprot, arprot;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [1:0]        bresp, rresp;
  logic [32*NREG-1:0] reg_q;
  logic [NREG-1:0]   reg_wstb;

  always #5 clk = ~clk;

  axi4_lite_slave_regfile #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32), .NUM_REGS(NREG)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(areset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready), .S_AXI_AWPROT(awprot),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready), .S_AXI_ARPROT(arprot),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .REG_Q(reg_q), .REG_WSTB(reg_wstb)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  int          compared = 0;
  int          mismatched = 0;
  logic [1:0]  b_q[$];
  r_exp_t      r_q[$];
  logic [31:0] model [NREG];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic check_regs(input string name);
    for (int i = 0; i < NREG; i++) begin
      check($sformatf("%s_reg%0d", name, i), reg_q[32*i +: 32], model[i]);
    end
  endtask

  // Monitor: responses are checked on the handshake cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (!areset && bvalid && bready) begin
      if (b_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_b: got bresp=%0d, expected no B beat", bresp);
      end else begin
        check("bresp", 32'(bresp), 32'(b_q.pop_front()));
      end
    end
    if (!areset && rvalid && rready) begin
      if (r_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_r: got rdata=0x%08h, expected no R beat", rdata);
      end else begin
        r_exp_t e;
        e = r_q.pop_front();
        check("rdata", rdata, e.data);
        check("rresp", 32'(rresp), 32'(e.resp));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cond(input int k);
    case (k)
      0: return awready && wready;
      1: return wready;
      2: return arready;
      3: return !bvalid;
      4: return !rvalid;
      5: return arready && awready && wready;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_cond(input int k);
    int n = 0;
    while (!cond(k) && n < 50) begin
      tick();
      n++;
    end
    if (!cond(k)) begin
      compared++;
      mismatched++;
      $display("FAIL timeout_cond%0d: got condition false after 50 cycles, expected true", k);
    end
  endtask

  task automatic write_both(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] resp);
    wait_cond(0);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    b_q.push_back(resp);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    r_exp_t e;
    wait_cond(2);
    araddr = a; arvalid = 1'b1;
    e.data = d; e.resp = resp;
    r_q.push_back(e);
    tick();
    arvalid = 1'b0;
    wait_cond(4);
  endtask

  initial begin
    areset = 1'b1;
    awaddr = '0; wdata = '0; wstrb = 4'hF; araddr = '0;
    awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    for (int i = 0; i < NREG; i++) model[i] = 32'd0;
    repeat (3) tick();

    // Reset state
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_bresp", 32'(bresp), 32'(RESP_OKAY));
    check("rst_rresp", 32'(rresp), 32'(RESP_OKAY));
    check("rst_rdata", rdata, 32'd0);
    check("rst_wstb", 32'(reg_wstb), 32'd0);
    check("rst_regq_any", 32'(|reg_q), 32'd0);
    areset = 1'b0;

    // Write A: AW and W together
    write_both(32'h08, 32'hDEADBEEF, 4'hF, RESP_OKAY);
    model[2] = 32'hDEADBEEF;
    check("wa_reg2", reg_q[64 +: 32], 32'hDEADBEEF);
    check("wa_bvalid", 32'(bvalid), 32'd1);
    check("wa_wstb", 32'(reg_wstb), 32'h0004);
    tick();
    check("wa_wstb_end", 32'(reg_wstb), 32'h0000);
    wait_cond(3);

    // Write B: W three cycles ahead of AW, partial strobe
    wait_cond(1);
    wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("wb_wready_held", 32'(wready), 32'd0);
    check("wb_awready", 32'(awready), 32'd1);
    tick();
    tick();
    check("wb_reg2_pre", reg_q[64 +: 32], 32'hDEADBEEF);
    check("wb_wstb_pre", 32'(reg_wstb), 32'h0000);
    awaddr = 32'h08; awvalid = 1'b1;
    b_q.push_back(RESP_OKAY);
    tick();
    awvalid = 1'b0; wstrb = 4'hF;
    model[2] = 32'hDE22BE44;
    check("wb_reg2", reg_q[64 +: 32], 32'hDE22BE44);
    check("wb_wstb", 32'(reg_wstb), 32'h0004);
    wait_cond(3);

    // Backpressure: B held 5 cycles while a second write waits
    bready = 1'b0;
    write_both(32'h0C, 32'h0BADCAFE, 4'hF, RESP_OKAY);
    model[3] = 32'h0BADCAFE;
    check("bp_reg3", reg_q[96 +: 32], 32'h0BADCAFE);
    awaddr = 32'h10; wdata = 32'h12345678; awvalid = 1'b1; wvalid = 1'b1;
    b_q.push_back(RESP_OKAY);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_bvalid_c%0d", c), 32'(bvalid), 32'd1);
      check($sformatf("bp_bresp_c%0d", c), 32'(bresp), 32'(RESP_OKAY));
      check($sformatf("bp_awready_c%0d", c), 32'(awready), 32'd0);
      check($sformatf("bp_wready_c%0d", c), 32'(wready), 32'd0);
      check($sformatf("bp_reg4_c%0d", c), reg_q[128 +: 32], 32'd0);
      tick();
    end
    bready = 1'b1;
    tick();
    check("bp_bvalid_after", 32'(bvalid), 32'd0);
    check("bp_awready_after", 32'(awready), 32'd1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    model[4] = 32'h12345678;
    check("bp_reg4", reg_q[128 +: 32], 32'h12345678);
    check("bp_bvalid2", 32'(bvalid), 32'd1);
    wait_cond(3);

    // Read collision: AR and write commit to reg2 on the same edge
    rready = 1'b0;
    wait_cond(5);
    begin
      r_exp_t e;
      e.data = 32'hDE22BE44; e.resp = RESP_OKAY;
      r_q.push_back(e);
    end
    b_q.push_back(RESP_OKAY);
    araddr = 32'h08; arvalid = 1'b1;
    awaddr = 32'h08; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    model[2] = 32'hCAFEF00D;
    check("rc_reg2", reg_q[64 +: 32], 32'hCAFEF00D);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("rc_rvalid_c%0d", c), 32'(rvalid), 32'd1);
      check($sformatf("rc_rdata_c%0d", c), rdata, 32'hDE22BE44);
      check($sformatf("rc_arready_c%0d", c), 32'(arready), 32'd0);
      tick();
    end
    rready = 1'b1;
    tick();
    check("rc_rvalid_after", 32'(rvalid), 32'd0);
    do_read(32'h08, 32'hCAFEF00D, RESP_OKAY);

    // Last register and ignored low address bits
    wait_cond(3);
    write_both(32'h3C, 32'hA5A5A5A5, 4'hF, RESP_OKAY);
    model[15] = 32'hA5A5A5A5;
    check("last_reg15", reg_q[480 +: 32], 32'hA5A5A5A5);
    check("last_wstb", 32'(reg_wstb), 32'h8000);
    do_read(32'h3C, 32'hA5A5A5A5, RESP_OKAY);
    do_read(32'h0A, 32'hCAFEF00D, RESP_OKAY);

    // Out of range: just past the end, and upper address bits set
    wait_cond(3);
    write_both(32'h40, 32'hFFFFFFFF, 4'hF, ERR);
    check("oor_wstb", 32'(reg_wstb), 32'h0000);
    check_regs("oor40");
    wait_cond(3);
    write_both(32'h80000008, 32'hFFFFFFFF, 4'hF, ERR);
    check("oorhi_wstb", 32'(reg_wstb), 32'h0000);
    check_regs("oorhi");
    do_read(32'h40, 32'd0, ERR);
    do_read(32'h80000008, 32'd0, ERR);

    // Reset while a B beat is pending
    wait_cond(3);
    bready = 1'b0;
    write_both(32'h14, 32'h55AA55AA, 4'hF, RESP_OKAY);
    check("rm_bvalid_pre", 32'(bvalid), 32'd1);
    areset = 1'b1;
    b_q.delete();
    r_q.delete();
    tick();
    for (int i = 0; i < NREG; i++) model[i] = 32'd0;
    check("rm_bvalid", 32'(bvalid), 32'd0);
    check("rm_regq_any", 32'(|reg_q), 32'd0);
    areset = 1'b0;
    bready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("rm_no_b_c%0d", c), 32'(bvalid), 32'd0);
    end
    check_regs("rm");
    do_read(32'h14, 32'd0, RESP_OKAY);
    repeat (3) tick();

    check("b_queue_empty", 32'(b_q.size()), 32'd0);
    check("r_queue_empty", 32'(r_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
